// File: rtl/mano_mem_seq_ctrl.sv
// rtl/mano_mem_seq_ctrl.sv - Mano sequence counter with memory read/write decode and req/ack handshake
module mano_mem_seq_ctrl #(
  parameter int SC_STATES = 16,
  parameter int TIMEOUT   = 64,
  parameter int TO_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 sc_clr,
  input  logic [7:0]           D,
  input  logic                 I,
  output logic [SC_STATES-1:0] T,
  output logic                 read,
  output logic                 write,
  output logic                 mem_req,
  output logic                 mem_we,
  input  logic                 mem_ack,
  output logic                 stall,
  output logic                 bus_err
);

  localparam int SC_W = $clog2(SC_STATES);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SC_STATES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {IDLE, REQ, ERR} state_e;

  state_e          state_q, state_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic            bus_err_q, bus_err_d;

  logic            t1, t3, t4, t6;
  logic            rd_need, wr_need, need;
  logic [SC_W-1:0] sc_inc;
  logic            unused_d4;

  // D4 (BUN) never touches memory in its execute step.
  assign unused_d4 = D[4];

  assign t1 = (sc_q == SC_W'(1));
  assign t3 = (sc_q == SC_W'(3));
  assign t4 = (sc_q == SC_W'(4));
  assign t6 = (sc_q == SC_W'(6));

  assign rd_need = t1 | (~D[7] & I & t3) | ((D[0] | D[1] | D[2] | D[6]) & t4);
  assign wr_need = ((D[3] | D[5]) & t4) | (D[6] & t6);
  assign read    = rd_need & run;
  assign write   = wr_need & run & ~rd_need;
  assign need    = read | write;

  assign sc_inc  = (sc_q == SC_LAST) ? '0 : sc_q + SC_W'(1);

  assign T       = SC_STATES'(1) << sc_q;
  assign mem_req = mem_req_q;
  assign mem_we  = mem_we_q;
  assign bus_err = bus_err_q;
  assign stall   = (state_q == ERR) ? 1'b1 : (need & ~((state_q == REQ) & mem_ack));

  always_comb begin
    state_d   = state_q;
    sc_d      = sc_q;
    cnt_d     = cnt_q;
    mem_req_d = mem_req_q;
    mem_we_d  = mem_we_q;
    bus_err_d = bus_err_q;
    case (state_q)
      IDLE: begin
        if (sc_clr) begin
          sc_d = '0;
        end else if (need) begin
          state_d   = REQ;
          mem_req_d = 1'b1;
          mem_we_d  = write;
          cnt_d     = '0;
        end else if (run) begin
          sc_d = sc_inc;
        end
      end
      REQ: begin
        // The access step is consumed on ack regardless of run.
        if (sc_clr) begin
          sc_d      = '0;
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else if (mem_ack) begin
          sc_d      = sc_inc;
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          state_d   = ERR;
          bus_err_d = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      ERR: begin
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sc_q      <= '0;
      cnt_q     <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sc_q      <= sc_d;
      cnt_q     <= cnt_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_mano_mem_seq_ctrl.sv
// tb/tb_mano_mem_seq_ctrl.sv - self-checking bench for mano_mem_seq_ctrl
module tb_mano_mem_seq_ctrl;

  logic        clk, rst, run, sc_clr, I, mem_ack;
  logic [7:0]  D;
  logic [15:0] T;
  logic        read, write, mem_req, mem_we, stall, bus_err;

  int n_pass  = 0;
  int n_total = 0;
  int lat     = 0;
  int age     = 0;
  bit resp_en = 1'b1;

  mano_mem_seq_ctrl #(.SC_STATES(16), .TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .run(run), .sc_clr(sc_clr), .D(D), .I(I),
    .T(T), .read(read), .write(write), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .stall(stall), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: acks after 'lat' wait cycles in each request.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (resp_en) begin
        if (mem_req) begin
          if (age >= lat) begin
            mem_ack = 1'b1;
            age = 0;
          end else begin
            mem_ack = 1'b0;
            age++;
          end
        end else begin
          mem_ack = 1'b0;
          age = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; sc_clr = 1'b0; D = 8'h00; I = 1'b0; mem_ack = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_until(input int k, input int budget);
    int n = 0;
    logic [15:0] want;
    want = 16'(1) << k;
    while (T !== want && n < budget) begin
      tick();
      n++;
    end
    n_total++;
    if (T !== want) $display("FAIL run_until_T%0d: T=%h required %h", k, T, want);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    n_total += 5;
    if (T !== 16'h0001) $display("FAIL reset_T: got %h want 0001", T); else n_pass++;
    if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req); else n_pass++;
    if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else n_pass++;
    if (bus_err !== 1'b0) $display("FAIL reset_bus_err: got %b want 0", bus_err); else n_pass++;
    if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else n_pass++;
  endtask

  task automatic test_fetch();
    do_reset(); resp_en = 1'b1; lat = 0; run = 1'b1;
    n_total++; if (T !== 16'h0001) $display("FAIL fetch_T0: got %h want 0001", T); else n_pass++;
    tick();
    n_total += 4;
    if (T !== 16'h0002) $display("FAIL fetch_T1: got %h want 0002", T); else n_pass++;
    if (read !== 1'b1) $display("FAIL fetch_read: got %b want 1", read); else n_pass++;
    if (mem_req !== 1'b0) $display("FAIL fetch_req_early: got %b want 0", mem_req); else n_pass++;
    if (stall !== 1'b1) $display("FAIL fetch_stall: got %b want 1", stall); else n_pass++;
    tick();
    n_total += 3;
    if (mem_req !== 1'b1) $display("FAIL fetch_req: got %b want 1", mem_req); else n_pass++;
    if (mem_we !== 1'b0) $display("FAIL fetch_we: got %b want 0", mem_we); else n_pass++;
    if (T !== 16'h0002) $display("FAIL fetch_T1_hold: got %h want 0002", T); else n_pass++;
    tick();
    n_total += 2;
    if (T !== 16'h0004) $display("FAIL fetch_T2: got %h want 0004", T); else n_pass++;
    if (mem_req !== 1'b0) $display("FAIL fetch_req_drop: got %b want 0", mem_req); else n_pass++;
  endtask

  task automatic test_sta_wait();
    int n = 0, st = 0;
    bit we_ok = 1'b1;
    do_reset(); resp_en = 1'b1; lat = 2; run = 1'b1; D = 8'h08;
    run_until(4, 40);
    n_total += 2;
    if (write !== 1'b1) $display("FAIL sta_write: got %b want 1", write); else n_pass++;
    if (read !== 1'b0) $display("FAIL sta_read: got %b want 0", read); else n_pass++;
    while (T === 16'h0010 && n < 20) begin
      if (stall) st++;
      if (mem_req && !mem_we) we_ok = 1'b0;
      n++;
      tick();
    end
    n_total += 4;
    if (n != 4) $display("FAIL sta_step_len: got %0d want 4", n); else n_pass++;
    if (st != 3) $display("FAIL sta_stall_cycles: got %0d want 3", st); else n_pass++;
    if (!we_ok) $display("FAIL sta_mem_we: got 0 want 1"); else n_pass++;
    if (T !== 16'h0020) $display("FAIL sta_T5: got %h want 0020", T); else n_pass++;
  endtask

  task automatic test_isz();
    int n = 0;
    do_reset(); resp_en = 1'b1; lat = 0; run = 1'b1; D = 8'h40;
    run_until(4, 40);
    n_total += 2;
    if (read !== 1'b1) $display("FAIL isz_read_T4: got %b want 1", read); else n_pass++;
    if (write !== 1'b0) $display("FAIL isz_write_T4: got %b want 0", write); else n_pass++;
    while (T === 16'h0010 && n < 20) begin
      n++;
      tick();
    end
    n_total += 4;
    if (n != 2) $display("FAIL isz_T4_len: got %0d want 2", n); else n_pass++;
    if (T !== 16'h0020) $display("FAIL isz_T5: got %h want 0020", T); else n_pass++;
    if (mem_req !== 1'b0) $display("FAIL isz_T5_req: got %b want 0", mem_req); else n_pass++;
    if (stall !== 1'b0) $display("FAIL isz_T5_stall: got %b want 0", stall); else n_pass++;
    tick();
    n_total += 2;
    if (T !== 16'h0040) $display("FAIL isz_T6: got %h want 0040", T); else n_pass++;
    if (write !== 1'b1) $display("FAIL isz_write_T6: got %b want 1", write); else n_pass++;
    tick();
    n_total += 2;
    if (mem_req !== 1'b1) $display("FAIL isz_req_T6: got %b want 1", mem_req); else n_pass++;
    if (mem_we !== 1'b1) $display("FAIL isz_we_T6: got %b want 1", mem_we); else n_pass++;
    tick();
    n_total++;
    if (T !== 16'h0080) $display("FAIL isz_T7: got %h want 0080", T); else n_pass++;
  endtask

  task automatic test_indirect();
    do_reset(); resp_en = 1'b1; lat = 0; run = 1'b1; D = 8'h01; I = 1'b1;
    run_until(3, 40);
    n_total++;
    if (read !== 1'b1) $display("FAIL ind_read: got %b want 1", read); else n_pass++;
    tick();
    n_total++;
    if (mem_req !== 1'b1) $display("FAIL ind_req: got %b want 1", mem_req); else n_pass++;
    do_reset(); run = 1'b1; D = 8'h80; I = 1'b1;
    run_until(3, 40);
    n_total += 2;
    if (read !== 1'b0) $display("FAIL d7_read: got %b want 0", read); else n_pass++;
    if (stall !== 1'b0) $display("FAIL d7_stall: got %b want 0", stall); else n_pass++;
    tick();
    n_total += 2;
    if (T !== 16'h0010) $display("FAIL d7_T4: got %h want 0010", T); else n_pass++;
    if (mem_req !== 1'b0) $display("FAIL d7_req: got %b want 0", mem_req); else n_pass++;
  endtask

  task automatic test_sc_clr_ack();
    do_reset(); resp_en = 1'b1; lat = 0; run = 1'b1;
    run_until(1, 20);
    tick();
    sc_clr = 1'b1;
    tick();
    sc_clr = 1'b0;
    n_total += 2;
    if (T !== 16'h0001) $display("FAIL clr_ack_T: got %h want 0001", T); else n_pass++;
    if (mem_req !== 1'b0) $display("FAIL clr_ack_req: got %b want 0", mem_req); else n_pass++;
    tick();
    n_total++;
    if (T !== 16'h0002) $display("FAIL clr_ack_resume: got %h want 0002", T); else n_pass++;
  endtask

  task automatic test_run_drop();
    do_reset(); resp_en = 1'b1; lat = 1; run = 1'b1;
    run_until(1, 20);
    tick();
    run = 1'b0;
    n_total++;
    if (mem_req !== 1'b1) $display("FAIL rdrop_req: got %b want 1", mem_req); else n_pass++;
    tick();
    n_total++;
    if (T !== 16'h0002) $display("FAIL rdrop_hold_T1: got %h want 0002", T); else n_pass++;
    tick();
    n_total += 2;
    if (T !== 16'h0004) $display("FAIL rdrop_adv: got %h want 0004", T); else n_pass++;
    if (mem_req !== 1'b0) $display("FAIL rdrop_req_drop: got %b want 0", mem_req); else n_pass++;
    tick();
    n_total++;
    if (T !== 16'h0004) $display("FAIL rdrop_sc_hold: got %h want 0004", T); else n_pass++;
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset(); resp_en = 1'b0; mem_ack = 1'b0; run = 1'b1;
    run_until(1, 20);
    tick();
    while (mem_req === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    n_total += 5;
    if (n != 4) $display("FAIL to_req_cycles: got %0d want 4", n); else n_pass++;
    if (bus_err !== 1'b1) $display("FAIL to_bus_err: got %b want 1", bus_err); else n_pass++;
    if (mem_req !== 1'b0) $display("FAIL to_req_low: got %b want 0", mem_req); else n_pass++;
    if (T !== 16'h0002) $display("FAIL to_T_frozen: got %h want 0002", T); else n_pass++;
    if (stall !== 1'b1) $display("FAIL to_stall: got %b want 1", stall); else n_pass++;
    sc_clr = 1'b1;
    tick(); tick();
    sc_clr = 1'b0;
    n_total += 2;
    if (T !== 16'h0002) $display("FAIL to_clr_ignored: got %h want 0002", T); else n_pass++;
    if (bus_err !== 1'b1) $display("FAIL to_err_sticky: got %b want 1", bus_err); else n_pass++;
    do_reset();
    n_total += 3;
    if (T !== 16'h0001) $display("FAIL to_rst_T: got %h want 0001", T); else n_pass++;
    if (bus_err !== 1'b0) $display("FAIL to_rst_err: got %b want 0", bus_err); else n_pass++;
    if (mem_req !== 1'b0) $display("FAIL to_rst_req: got %b want 0", mem_req); else n_pass++;
  endtask

  // Reference: SC as an integer, an outstanding access flag and a wait count.
  task automatic test_random();
    int m_sc = 0, m_wait = 0;
    bit m_busy = 0, m_err = 0, m_we = 0;
    bit rdn, wrn, e_rd, e_wr, e_stall;
    logic [15:0] e_T;
    do_reset(); resp_en = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick();
      rst    = (m_err || $urandom_range(0, 59) == 0);
      run    = ($urandom_range(0, 9) != 0);
      sc_clr = ($urandom_range(0, 24) == 0);
      D      = ($urandom_range(0, 3) != 0) ? (8'h01 << $urandom_range(0, 7)) : 8'($urandom);
      I      = 1'($urandom_range(0, 1));
      mem_ack = ($urandom_range(0, 2) == 0);
      #1;
      rdn = (m_sc == 1) || (!D[7] && I && m_sc == 3) || ((D[0] || D[1] || D[2] || D[6]) && m_sc == 4);
      wrn = ((D[3] || D[5]) && m_sc == 4) || (D[6] && m_sc == 6);
      e_rd = rdn && run;
      e_wr = wrn && run && !rdn;
      e_stall = m_err ? 1'b1 : ((e_rd || e_wr) && !(m_busy && mem_ack));
      e_T = 16'(1) << m_sc;
      n_total += 6;
      if (T !== e_T) $display("FAIL rnd_T cyc%0d: got %h want %h", i, T, e_T); else n_pass++;
      if (read !== e_rd) $display("FAIL rnd_read cyc%0d: got %b want %b", i, read, e_rd); else n_pass++;
      if (write !== e_wr) $display("FAIL rnd_write cyc%0d: got %b want %b", i, write, e_wr); else n_pass++;
      if (mem_req !== m_busy) $display("FAIL rnd_req cyc%0d: got %b want %b", i, mem_req, m_busy); else n_pass++;
      if (stall !== e_stall) $display("FAIL rnd_stall cyc%0d: got %b want %b", i, stall, e_stall); else n_pass++;
      if (bus_err !== m_err) $display("FAIL rnd_err cyc%0d: got %b want %b", i, bus_err, m_err); else n_pass++;
      if (m_busy) begin
        n_total++;
        if (mem_we !== m_we) $display("FAIL rnd_we cyc%0d: got %b want %b", i, mem_we, m_we); else n_pass++;
      end
      if (rst) begin
        m_sc = 0; m_busy = 0; m_err = 0; m_we = 0; m_wait = 0;
      end else if (m_err) begin
      end else if (sc_clr) begin
        m_sc = 0; m_busy = 0;
      end else if (m_busy) begin
        if (mem_ack) begin
          m_busy = 0; m_sc = (m_sc + 1) % 16;
        end else if (m_wait == 3) begin
          m_busy = 0; m_err = 1;
        end else begin
          m_wait++;
        end
      end else if (e_rd || e_wr) begin
        m_busy = 1; m_we = e_wr; m_wait = 0;
      end else if (run) begin
        m_sc = (m_sc + 1) % 16;
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; sc_clr = 1'b0; D = 8'h00; I = 1'b0; mem_ack = 1'b0;
    test_reset();
    test_fetch();
    test_sta_wait();
    test_isz();
    test_indirect();
    test_sc_clr_ack();
    test_run_drop();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mano_mem_seq_ctrl.md
Name: mano_mem_seq_ctrl

Overview:
- Parametrised successor to the Mano basic-computer memory read/write decode.
- Owns the sequence counter (SC) and its one-hot timing outputs T.
- Generates both READ and WRITE for fetch, indirect and memory-reference execute steps.
- Runs a req/ack handshake with a variable-latency memory, stalls SC until the access completes, and flags a bus error on timeout.

Parameters:
- SC_STATES, 16, number of timing states; SC width = clog2(SC_STATES); minimum 8.
- TIMEOUT, 64, max cycles in REQ without mem_ack before bus error; 0 disables the timeout.
- TO_W, 8, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- run, input, 1, start/stop flip-flop S; 1 = execute.
- sc_clr, input, 1, clear SC (end of instruction or interrupt entry).
- D, input, 8, one-hot opcode decode D0..D7.
- I, input, 1, indirect bit from IR(15).
- T, output, SC_STATES, one-hot timing signals decoded from SC.
- read, output, 1, combinational memory-read request for the current timing step.
- write, output, 1, combinational memory-write request for the current timing step.
- mem_req, output, 1, registered request to memory.
- mem_we, output, 1, registered; 1 = write, valid while mem_req = 1.
- mem_ack, input, 1, memory completion strobe (one cycle).
- stall, output, 1, 1 while SC is held waiting on memory.
- bus_err, output, 1, sticky timeout flag.

Behaviour:
- Reset (rst=1 at an edge): SC=0 (T=...0001); FSM=IDLE; mem_req=0; mem_we=0; timeout counter=0; bus_err=0. Reset overrides every other input, including mid-transaction; the memory side must tolerate a dropped mem_req.
- Access decode (combinational, each gated by run):
  - rd_need = T1 | (~D7 & I & T3) | ((D0|D1|D2|D6) & T4).
  - wr_need = ((D3|D5) & T4) | (D6 & T6).
  - If both are asserted (non-one-hot D): read wins, write is forced 0.
  - read = rd_need & run; write = wr_need & run & ~rd_need.
  - need = read | write.
- FSM states: IDLE, REQ, ERR.
  - IDLE:
    - need=1: go to REQ; mem_req<=1; mem_we<=write; counter<=0.
    - need=0 and run=1: SC<=SC+1, wrapping from SC_STATES-1 to 0.
    - run=0: SC holds.
  - REQ:
    - mem_req=1; mem_we stable.
    - mem_ack=1: go to IDLE; mem_req<=0; SC<=SC+1 on the same edge, even if run has since dropped, so the access step is consumed.
    - No ack: counter increments.
    - counter reaches TIMEOUT-1 with no ack (TIMEOUT≠0): go to ERR; bus_err<=1; mem_req<=0.
  - ERR: SC frozen; mem_req=0; read/write still decode; only rst exits.
- Latency: an access step lasts 1 + (cycles until ack) clocks. With ack in the first REQ cycle, the step lasts 2 clocks.
- stall = need & ~(REQ & mem_ack) in IDLE/REQ; stall = 1 in ERR.
- sc_clr:
  - In IDLE/REQ it has priority over increment and ack: SC<=0; FSM<=IDLE; mem_req<=0. A pending access is abandoned and a simultaneous ack is ignored.
  - In ERR it is ignored.
- mem_ack outside REQ is ignored.
- run falling while in REQ does not abort the transaction; it only blocks new requests.
- T = one-hot of SC at all times.

Test Plan:
- Fetch, zero-wait: rst, run=1, mem_ack tied to mem_req → T0 for 1 clk; T1 for 2 clks with read=1, mem_req=1, mem_we=0 for 1 clk; then T2.
- STA (D3) with 3-cycle memory: ack 3 clks after mem_req rises → at T4, write=1, mem_we=1, stall=1 for 3 clks; T5 after the ack edge; SC never advances early.
- ISZ (D6): read at T4 and write at T6, each with one handshake; T5 advances without mem_req.
- Indirect (D7=0, I=1) at T3 → read=1; same with D7=1 → read=0, no request, SC advances immediately.
- Timeout, TIMEOUT=4, ack never asserted → mem_req high exactly 4 clks, then bus_err=1, mem_req=0, T frozen; rst clears everything to T0.
- sc_clr coincident with mem_ack in REQ → next cycle SC=0, mem_req=0, no increment. Run dropped mid-REQ → ack still advances SC by one, then SC holds.
